// File: rtl/fix2fp_if.sv
// Valid/ready stream bundle for the fixed-to-float converter: fixed-point samples in, float words out.
interface fix2fp_if #(
  parameter int IW = 32,
  parameter int OW = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [IW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic        [OW-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fix2fp_conv.sv
// Three-stage signed fixed-point to float converter with valid/ready handshake and bubble collapsing.
// Optional macro FIX2FP_RNE_EN: round-to-nearest-even in S3 instead of truncation.
module fix2fp_conv #(
  parameter int IW    = 32,
  parameter int FRAC  = 16,
  parameter int I_EXP = 8,
  parameter int I_MNT = 23
) (
  input logic     clk,
  input logic     reset,
  fix2fp_if.slave io
);

  localparam int OW    = I_EXP + I_MNT + 1;
  localparam int PW    = $clog2(IW);
  localparam int EXP_W = I_EXP + 2;
  localparam int BIAS  = (1 << (I_EXP - 1)) - 1;
  localparam int FW    = IW + I_MNT;

  localparam logic signed [EXP_W-1:0] EXP_FRAC = EXP_W'(FRAC);
  localparam logic signed [EXP_W-1:0] EXP_BIAS = EXP_W'(BIAS);
  localparam logic signed [EXP_W-1:0] EXP_ZERO = '0;
  localparam logic signed [EXP_W-1:0] EXP_SAT  = EXP_W'((1 << I_EXP) - 1);

  // Scan upward so the highest set bit is the one that sticks.
  function automatic logic [PW-1:0] lead_one(input logic [IW-1:0] m);
    lead_one = '0;
    for (int i = 0; i < IW; i++) begin
      if (m[i]) lead_one = PW'(i);
    end
  endfunction

`ifdef FIX2FP_RNE_EN
  function automatic logic [I_MNT:0] round_rne(input logic [I_MNT-1:0] mant,
                                               input logic guard,
                                               input logic sticky);
    round_rne = {1'b0, mant} + (I_MNT+1)'(guard && (sticky || mant[0]));
  endfunction
`endif

  function automatic logic [OW-1:0] saturate(input logic                    sign,
                                             input logic                    zero,
                                             input logic signed [EXP_W-1:0] exp_b,
                                             input logic        [I_MNT-1:0] mant);
    if (zero || exp_b <= EXP_ZERO)
      saturate = '0;
    else if (exp_b >= EXP_SAT)
      saturate = {sign, I_EXP'((1 << I_EXP) - 2), {I_MNT{1'b1}}};
    else
      saturate = {sign, exp_b[I_EXP-1:0], mant};
  endfunction

  logic                    vld_p0, vld_p1, vld_p2;
  logic                    ld_p0, ld_p1, ld_p2;
  logic                    in_fire;

  logic                    sign_p0;
  logic        [IW-1:0]    mag_p0;
  logic        [IW-1:0]    raw_s1, mag_s1;

  logic                    sign_p1, zero_p1;
  logic signed [EXP_W-1:0] exp_p1;
  logic        [I_MNT-1:0] mant_p1;
  logic        [PW-1:0]    lead_s2;
  logic        [IW-1:0]    norm_s2;
  logic        [FW-2:0]    frac_s2;
  logic signed [EXP_W-1:0] e_s2, exp_s2;
  logic        [I_MNT-1:0] mant_s2;
`ifdef FIX2FP_RNE_EN
  logic                    guard_p1, sticky_p1;
  logic                    guard_s2, sticky_s2;
  logic        [I_MNT:0]   rnd_s3;
`endif

  logic        [OW-1:0]    data_p2;
  logic signed [EXP_W-1:0] exp_s3;
  logic        [I_MNT-1:0] mant_s3;
  logic        [OW-1:0]    data_s3;

  assign ld_p2   = !vld_p2 || io.out_ready;
  assign ld_p1   = !vld_p1 || ld_p2;
  assign ld_p0   = !vld_p0 || ld_p1;
  assign io.in_ready  = ld_p0 && !reset;
  assign in_fire      = io.in_valid && io.in_ready;
  assign io.out_valid = vld_p2;
  assign io.out_data  = data_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (ld_p0) vld_p0 <= in_fire;
      if (ld_p1) vld_p1 <= vld_p0;
      if (ld_p2) vld_p2 <= vld_p1;
    end
  end

  // ---- S1: sign and magnitude (most negative input maps to 2^(IW-1)) ----
  always_comb begin
    raw_s1 = io.in_data;
    mag_s1 = raw_s1[IW-1] ? (~raw_s1 + IW'(1)) : raw_s1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sign_p0 <= 1'b0;
      mag_p0  <= '0;
    end else if (ld_p0 && in_fire) begin
      sign_p0 <= raw_s1[IW-1];
      mag_p0  <= mag_s1;
    end
  end

  // ---- S2: normalise, exponent, mantissa field ----
  always_comb begin
    lead_s2 = lead_one(mag_p0);
    norm_s2 = mag_p0 << (PW'(IW - 1) - lead_s2);
    frac_s2 = {norm_s2[IW-2:0], {I_MNT{1'b0}}};
    mant_s2 = I_MNT'(frac_s2 >> (IW - 1));
    e_s2    = $signed(EXP_W'(lead_s2)) - EXP_FRAC;
    exp_s2  = e_s2 + EXP_BIAS;
`ifdef FIX2FP_RNE_EN
    guard_s2  = frac_s2[IW-2];
    sticky_s2 = |(frac_s2 << (I_MNT + 1));
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sign_p1   <= 1'b0;
      zero_p1   <= 1'b0;
      exp_p1    <= '0;
      mant_p1   <= '0;
`ifdef FIX2FP_RNE_EN
      guard_p1  <= 1'b0;
      sticky_p1 <= 1'b0;
`endif
    end else if (ld_p1 && vld_p0) begin
      sign_p1   <= sign_p0;
      zero_p1   <= ~norm_s2[IW-1];
      exp_p1    <= exp_s2;
      mant_p1   <= mant_s2;
`ifdef FIX2FP_RNE_EN
      guard_p1  <= guard_s2;
      sticky_p1 <= sticky_s2;
`endif
    end
  end

  // ---- S3: optional rounding, flush/saturate, pack ----
  always_comb begin
`ifdef FIX2FP_RNE_EN
    rnd_s3  = round_rne(mant_p1, guard_p1, sticky_p1);
    exp_s3  = rnd_s3[I_MNT] ? (exp_p1 + EXP_W'(1)) : exp_p1;
    mant_s3 = rnd_s3[I_MNT-1:0];
`else
    exp_s3  = exp_p1;
    mant_s3 = mant_p1;
`endif
    data_s3 = saturate(sign_p1, zero_p1, exp_s3, mant_s3);
  end

  always_ff @(posedge clk) begin
    if (reset)
      data_p2 <= '0;
    else if (ld_p2 && vld_p1)
      data_p2 <= data_s3;
  end

endmodule

// File: tb/tb_fix2fp_conv.sv
// Directed and random handshake bench for fix2fp_conv (Q16.16 in, 1/8/23 float out).
module tb_fix2fp_conv;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fix2fp_if #(.IW(32), .OW(32)) bus();

  fix2fp_conv #(.IW(32), .FRAC(16), .I_EXP(8), .I_MNT(23)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  logic [31:0] specials[8];

`ifdef FIX2FP_RNE_EN
  localparam logic [31:0] EXP_MAXPOS = 32'h47000000;
`else
  localparam logic [31:0] EXP_MAXPOS = 32'h46FFFFFF;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference through IEEE double: every 32-bit Q16.16 value is exact there.
  function automatic logic [31:0] model(input int x);
    real         r;
    logic [63:0] db;
    int          e;
    logic [23:0] mr;
    if (x == 0) return 32'h0;
    r  = $itor(x) / 65536.0;
    db = $realtobits(r);
    e  = int'(db[62:52]) - 1023 + 127;
    mr = {1'b0, db[51:29]};
`ifdef FIX2FP_RNE_EN
    if (db[28] && ((|db[27:0]) || mr[0])) mr = mr + 24'd1;
    if (mr[23]) begin
      mr = 24'd0;
      e++;
    end
`endif
    if (e <= 0) return 32'h0;
    if (e >= 255) return {db[63], 8'hFE, 23'h7FFFFF};
    return {db[63], e[7:0], mr[22:0]};
  endfunction

  task automatic conv(input string tag, input logic [31:0] x, input logic [31:0] exp);
    bus.in_valid  = 1'b1;
    bus.in_data   = x;
    bus.out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
    tick();
    chk({tag, "_lat2"}, 32'(bus.out_valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_data"}, bus.out_data, exp);
    tick();
    chk({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    specials = '{32'h00000000, 32'h80000000, 32'h7FFFFFFF, 32'h00000001,
                 32'hFFFFFFFF, 32'h00010000, 32'hFFFF0000, 32'h00008000};
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_data", bus.out_data, 32'h0);
    reset = 1'b0;
    tick();
    chk("post_reset_in_ready", 32'(bus.in_ready), 32'd1);

    conv("one",     32'h00010000, 32'h3F800000);
    conv("neg_one", 32'hFFFF0000, 32'hBF800000);
    conv("most_neg", 32'h80000000, 32'hC7000000);
    conv("lsb",     32'h00000001, 32'h37800000);
    conv("zero",    32'h00000000, 32'h00000000);
    conv("max_pos", 32'h7FFFFFFF, EXP_MAXPOS);
    conv("half",    32'h00008000, 32'h3F000000);

    // Backpressure: fill all three stages with the output blocked.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h00010000;
    tick();
    bus.in_data   = 32'h00020000;
    tick();
    bus.in_data   = 32'h00030000;
    tick();
    bus.in_data   = 32'h00040000;
    #1;
    chk("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
    chk("bp_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_hold0", bus.out_data, 32'h3F800000);
    tick();
    chk("bp_hold1", bus.out_data, 32'h3F800000);
    chk("bp_in_ready_stall", 32'(bus.in_ready), 32'd0);
    tick();
    chk("bp_hold2", bus.out_data, 32'h3F800000);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("bp_in_ready_comb", 32'(bus.in_ready), 32'd1);
    chk("bp_out0", bus.out_data, 32'h3F800000);
    tick();
    chk("bp_out1", bus.out_data, 32'h40000000);
    chk("bp_out1_valid", 32'(bus.out_valid), 32'd1);
    tick();
    chk("bp_out2", bus.out_data, 32'h40400000);
    chk("bp_out2_valid", 32'(bus.out_valid), 32'd1);
    tick();
    chk("bp_empty", 32'(bus.out_valid), 32'd0);

    // Reset with three samples in flight.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.in_data = 32'(i) << 16;
      tick();
    end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("rst_mid_valid0", 32'(bus.out_valid), 32'd0);
    chk("rst_mid_data0", bus.out_data, 32'h0);
    tick();
    chk("rst_mid_valid1", 32'(bus.out_valid), 32'd0);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_no_stale", 32'(bus.out_valid), 32'd0);
    end

    // Random valid/ready stress against the double-precision reference.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 7)] : $urandom;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        chk("stress_sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) chk("stress_data", bus.out_data, sb.pop_front());
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.in_data));
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.out_valid) begin
        chk("drain_sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) chk("drain_data", bus.out_data, sb.pop_front());
      end
      tick();
    end
    chk("stress_all_emitted", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
